// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running pixel/line counters with registered
// sync and blanking decode, plus single-cycle line and frame start strobes.
// All decode is taken from the next-state counters and then registered, so
// every output field in a given cycle describes the same pixel.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  // Sync window ends are kept 12 bits wide so a pulse that runs to the very
  // end of a 2048-count line does not wrap the bound to zero.
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Counter advance and wrap detection; strobes only fire on an enabled wrap.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d      = 11'd0;
        line_start_d = 1'b1;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = 11'd0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 11'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
  end

  // Sync/blank decode of the next-state counters; holding counters hold these too.
  always_comb begin
    hblnk_d = (h_cnt_d >= H_ACT);
    vblnk_d = (v_cnt_d >= V_ACT);
    hsync_d = (({1'b0, h_cnt_d} >= HS_START) && ({1'b0, h_cnt_d} < HS_END))
              ? SYNC_POL : ~SYNC_POL;
    vsync_d = (({1'b0, v_cnt_d} >= VS_START) && ({1'b0, v_cnt_d} < VS_END))
              ? SYNC_POL : ~SYNC_POL;
  end

  // State and output registers; reset lands on pixel (0,0) with syncs inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 11'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = h_cnt_q;
  assign vcount      = v_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign rgb         = 12'h000;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default 800x600 instance and one tiny
// negative-sync instance, both checked every cycle against a pixel-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults
  logic        rst_a = 1'b1, en_a = 1'b0;
  logic [10:0] hcount_a, vcount_a;
  logic        hsync_a, vsync_a, hblnk_a, vblnk_a, frame_start_a, line_start_a;
  logic [11:0] rgb_a;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .en(en_a),
    .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
    .hblnk(hblnk_a), .vblnk(vblnk_a), .rgb(rgb_a),
    .frame_start(frame_start_a), .line_start(line_start_a)
  );

  // Instance B: H 4/1/2/1, V 3/1/1/1, negative sync
  logic        rst_b = 1'b1, en_b = 1'b0;
  logic [10:0] hcount_b, vcount_b;
  logic        hsync_b, vsync_b, hblnk_b, vblnk_b, frame_start_b, line_start_b;
  logic [11:0] rgb_b;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b),
    .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
    .hblnk(hblnk_b), .vblnk(vblnk_b), .rgb(rgb_b),
    .frame_start(frame_start_b), .line_start(line_start_b)
  );

  // Model state: number of enabled cycles since reset, and whether the last edge advanced.
  longint n_a = 0, n_b = 0;
  bit adv_a = 0, adv_b = 0, valid_a = 0, valid_b = 0;

  always @(posedge clk) begin
    if (rst_a) begin n_a <= 0; adv_a <= 0; valid_a <= 1; end
    else if (en_a) begin n_a <= n_a + 1; adv_a <= 1; end
    else adv_a <= 0;
    if (rst_b) begin n_b <= 0; adv_b <= 0; valid_b <= 1; end
    else if (en_b) begin n_b <= n_b + 1; adv_b <= 1; end
    else adv_b <= 0;
  end

  // Expected {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb, frame_start, line_start}
  function automatic logic [39:0] model(longint n, bit adv,
                                        int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb, bit pol);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int h = int'(n % longint'(ht));
    int v = int'((n / longint'(ht)) % longint'(vt));
    bit hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
    bit vsy = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
    bit ls = adv && (n % longint'(ht) == 0);
    bit fs = adv && (n % longint'(ht * vt) == 0);
    bit hb_ = (h >= ha);
    bit vb_ = (v >= va);
    return {11'(h), 11'(v), hsy, vsy, hb_, vb_, 12'h000, fs, ls};
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [39:0] exp_v, act_v;
    if (valid_a) begin
      exp_v = model(n_a, adv_a, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1);
      act_v = {hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, rgb_a,
               frame_start_a, line_start_a};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_a n=%0d actual=%h expected=%h", n_a, act_v, exp_v);
      end
    end
    if (valid_b) begin
      exp_v = model(n_b, adv_b, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0);
      act_v = {hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b, rgb_b,
               frame_start_b, line_start_b};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_b n=%0d actual=%h expected=%h", n_b, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  initial begin
    int cnt;
    bit found;

    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state, literal values
    chk("rst_hcount_a", 32'(hcount_a), 0);
    chk("rst_vcount_a", 32'(vcount_a), 0);
    chk("rst_sync_a", {30'd0, hsync_a, vsync_a}, 0);
    chk("rst_blnk_a", {30'd0, hblnk_a, vblnk_a}, 0);
    chk("rst_strobe_a", {30'd0, frame_start_a, line_start_a}, 0);
    chk("rst_sync_b", {30'd0, hsync_b, vsync_b}, 3);

    // First line on A, pinning decode boundaries
    en_a = 1'b1;
    for (int i = 1; i <= 1056; i++) begin
      @(negedge clk);
      if (i == 1)    chk("first_hcount", 32'(hcount_a), 1);
      if (i == 799)  chk("hblnk_799", 32'(hblnk_a), 0);
      if (i == 800)  chk("hblnk_800", 32'(hblnk_a), 1);
      if (i == 839)  chk("hsync_839", 32'(hsync_a), 0);
      if (i == 840)  chk("hsync_840", 32'(hsync_a), 1);
      if (i == 967)  chk("hsync_967", 32'(hsync_a), 1);
      if (i == 968)  chk("hsync_968", 32'(hsync_a), 0);
      if (i == 1055) chk("hcount_1055", 32'(hcount_a), 1055);
      if (i == 1056) begin
        chk("wrap_hcount", 32'(hcount_a), 0);
        chk("wrap_vcount", 32'(vcount_a), 1);
        chk("wrap_line_start", 32'(line_start_a), 1);
        chk("wrap_frame_start", 32'(frame_start_a), 0);
      end
    end

    // Random enable on both instances, occasional resets of B
    for (int i = 0; i < 10000; i++) begin
      en_a  = 1'($urandom_range(0, 1));
      en_b  = 1'($urandom_range(0, 1));
      rst_b = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    rst_b = 1'b0;

    // Mid-frame reset on A at hcount 500, with en high
    en_a  = 1'b1;
    found = 0;
    for (int i = 0; i < 2200 && !found; i++) begin
      @(negedge clk);
      if (hcount_a == 11'd500) found = 1;
    end
    chk("reach_h500", 32'(found), 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_hcount", 32'(hcount_a), 0);
    chk("midrst_vcount", 32'(vcount_a), 0);
    chk("midrst_sync", {30'd0, hsync_a, vsync_a}, 0);
    chk("midrst_strobe", {30'd0, frame_start_a, line_start_a}, 0);
    rst_a = 1'b0;
    @(negedge clk);
    chk("restart_hcount", 32'(hcount_a), 1);

    // Frame period on B with en held high, and polarity pins
    en_b  = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (frame_start_b) found = 1;
    end
    chk("fs_seen_b", 32'(found), 1);
    cnt   = 0;
    found = 0;
    while (!found && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (hcount_b == 11'd5) chk("b_hsync_5", 32'(hsync_b), 0);
      if (hcount_b == 11'd6) chk("b_hsync_6", 32'(hsync_b), 0);
      if (hcount_b == 11'd7) chk("b_hsync_7", 32'(hsync_b), 1);
      if (hcount_b == 11'd4) chk("b_hsync_4", 32'(hsync_b), 1);
      if (vcount_b == 11'd4) chk("b_vsync_4", 32'(vsync_b), 0);
      if (vcount_b == 11'd3) chk("b_vsync_3", 32'(vsync_b), 1);
      if (frame_start_b) begin
        found = 1;
        chk("fs_line_start_b", 32'(line_start_b), 1);
      end
    end
    chk("fs_period_b", 32'(cnt), 48);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
